// File: rtl/aca_csu_vl_ctrl.sv
// aca_csu_vl_ctrl: variable-latency controller around an ACA-CSU approximate adder.
// A transaction is added speculatively (block carry guessed from the previous
// block only). Blocks with a wrong guess are flagged. In exact mode, they are then
// repaired one per cycle, lowest block first, using the true carry-in.
module aca_csu_vl_ctrl #(
   parameter int WIDTH = 32,
   parameter int BLK   = 4,
   parameter int CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   input  logic                           mode_exact,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH:0]                 sum,
   output logic                           err_flag,
   output logic [$clog2(WIDTH/BLK)-1:0]   err_nblk,
   output logic [CNT_W-1:0]               err_cnt,
   input  logic                           cnt_clr
);

   localparam int NBLK = WIDTH / BLK;
   localparam int NW   = $clog2(NBLK);

   typedef enum logic [1:0] {S_IDLE, S_SPEC, S_CORR, S_DONE} state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               mode_q;
   logic [WIDTH:0]     sum_q;
   logic [NBLK-1:0]    mask_q;
   logic               err_flag_q;
   logic [NW-1:0]      err_nblk_q;
   logic               in_ready_q, out_valid_q;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic [NBLK-1:0]    gen, prop, cin_spec, cin_exact, mask_spec;
   logic               cout_spec, cout_exact;
   logic [WIDTH:0]     sum_spec;
   logic [WIDTH:0]     corr_sum;
   logic [NBLK-1:0]    corr_mask;
   logic               corr_found;

   // Number of blocks whose speculated carry-in was wrong.
   function automatic logic [NW-1:0] popcount(input logic [NBLK-1:0] m);
      logic [NW-1:0] c;
      c = '0;
      for (int i = 0; i < NBLK; i++) c = c + NW'(m[i]);
      return c;
   endfunction

   // Block generate/propagate, speculative and exact carries, speculative sum.
   always_comb begin
      gen       = '0;
      prop      = '0;
      cin_spec  = '0;
      cin_exact = '0;
      sum_spec  = '0;
      for (int k = 0; k < NBLK; k++) begin
         // Carry out of a+b (cin=0) exists exactly when a > ~b.
         gen[k]  = a_q[BLK*k +: BLK] > ~b_q[BLK*k +: BLK];
         prop[k] = &(a_q[BLK*k +: BLK] ^ b_q[BLK*k +: BLK]);
      end
      cin_spec[1]  = gen[0];
      cin_exact[1] = gen[0];
      for (int k = 2; k < NBLK; k++) begin
         // A fully propagating neighbour forwards the generate of the bit just below it.
         cin_spec[k]  = prop[k-1] ? (a_q[BLK*(k-1)-1] & b_q[BLK*(k-1)-1]) : gen[k-1];
         cin_exact[k] = gen[k-1] | (prop[k-1] & cin_exact[k-1]);
      end
      for (int k = 0; k < NBLK; k++) begin
         sum_spec[BLK*k +: BLK] = a_q[BLK*k +: BLK] + b_q[BLK*k +: BLK]
                                  + {{(BLK-1){1'b0}}, cin_spec[k]};
      end
      cout_spec      = gen[NBLK-1] | (prop[NBLK-1] & cin_spec[NBLK-1]);
      cout_exact     = gen[NBLK-1] | (prop[NBLK-1] & cin_exact[NBLK-1]);
      sum_spec[WIDTH] = cout_spec;
      mask_spec      = cin_spec ^ cin_exact;
   end

   // Repair of the lowest still-wrong block with its true carry-in.
   always_comb begin
      corr_sum   = sum_q;
      corr_mask  = mask_q;
      corr_found = 1'b0;
      for (int k = 1; k < NBLK; k++) begin
         if (!corr_found && mask_q[k]) begin
            corr_found = 1'b1;
            corr_mask[k] = 1'b0;
            corr_sum[BLK*k +: BLK] = a_q[BLK*k +: BLK] + b_q[BLK*k +: BLK]
                                     + {{(BLK-1){1'b0}}, cin_exact[k]};
            if (k == NBLK-1) corr_sum[WIDTH] = cout_exact;
         end
      end
   end

   // Transaction FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= 1'b0;
         sum_q       <= '0;
         mask_q      <= '0;
         err_flag_q  <= 1'b0;
         err_nblk_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  mode_q     <= mode_exact;
                  in_ready_q <= 1'b0;
                  state_q    <= S_SPEC;
               end
            end
            S_SPEC: begin
               sum_q      <= sum_spec;
               mask_q     <= mask_spec;
               err_flag_q <= |mask_spec;
               err_nblk_q <= popcount(mask_spec);
               if (mask_spec == '0 || !mode_q) begin
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  state_q <= S_CORR;
               end
            end
            S_CORR: begin
               sum_q  <= corr_sum;
               mask_q <= corr_mask;
               if (corr_mask == '0) begin
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Saturating count of erroneous transactions; clear wins over increment.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (cnt_clr)
         err_cnt_d = '0;
      else if (state_q == S_SPEC && (|mask_spec) && err_cnt_q != '1)
         err_cnt_d = err_cnt_q + 1'b1;
   end

   // Error counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign err_flag  = err_flag_q;
   assign err_nblk  = err_nblk_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_aca_csu_vl_ctrl.sv
// Bench for aca_csu_vl_ctrl: directed and randomized transactions, compared
// against a block-arithmetic reference of the ACA-CSU rules.
module tb_aca_csu_vl_ctrl;

   localparam int WIDTH = 32;
   localparam int BLK   = 4;
   localparam int NBLK  = 8;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready;
   logic [WIDTH-1:0]  a, b;
   logic              mode_exact;
   logic              out_valid, out_ready;
   logic [WIDTH:0]    sum;
   logic              err_flag;
   logic [2:0]        err_nblk;
   logic [CNT_W-1:0]  err_cnt;
   logic              cnt_clr;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_m = 0;

   aca_csu_vl_ctrl #(.WIDTH(WIDTH), .BLK(BLK), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode_exact(mode_exact), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .err_flag(err_flag),
      .err_nblk(err_nblk), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   // Reference: speculative and exact sums from the block carry rules.
   function automatic void ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                     input logic rm, output logic [32:0] rs,
                                     output int rn, output int rlat);
      logic [32:0] ex;
      logic [32:0] sp;
      longint unsigned lo_a, lo_b, msk;
      int ak, bk, ap, bp, cin, cex, blk;
      ex = {1'b0, ra} + {1'b0, rb};
      sp = '0;
      rn = 0;
      for (int k = 0; k < NBLK; k++) begin
         ak = int'((ra >> (4*k)) & 32'hF);
         bk = int'((rb >> (4*k)) & 32'hF);
         msk  = (64'd1 << (4*k)) - 64'd1;
         lo_a = longint'(ra) & msk;
         lo_b = longint'(rb) & msk;
         cex  = int'(((lo_a + lo_b) >> (4*k)) & 64'd1);
         if (k == 0) cin = 0;
         else begin
            ap = int'((ra >> (4*(k-1))) & 32'hF);
            bp = int'((rb >> (4*(k-1))) & 32'hF);
            if (k >= 2 && (ap ^ bp) == 15)
               cin = int'((ra >> (4*(k-1)-1)) & (rb >> (4*(k-1)-1)) & 32'h1);
            else
               cin = (ap + bp) >> 4;
         end
         if (cin != cex) rn++;
         blk = ak + bk + cin;
         sp = sp | (33'(blk & 15) << (4*k));
         if (k == NBLK-1) sp[32] = blk[4];
      end
      rs   = (rm && rn > 0) ? ex : sp;
      rlat = (rm && rn > 0) ? 2 + rn : 2;
   endfunction

   function automatic int cnt_next(input int c, input int nb, input logic clr);
      if (clr) return 0;
      if (nb > 0 && c < CMAX) return c + 1;
      return c;
   endfunction

   // One transaction: present, count edges to out_valid (bounded), accept result.
   task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tm, input logic clr_in_spec,
                          output logic [32:0] os, output logic of,
                          output logic [2:0] on, output int olat);
      a = ta; b = tb_; mode_exact = tm; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; mode_exact = $urandom_range(0, 1);
      cnt_clr = clr_in_spec;
      olat = 1;
      while (!out_valid && olat < 40) begin
         @(posedge clk); #1;
         cnt_clr = 1'b0;
         olat++;
      end
      cnt_clr = 1'b0;
      os = sum; of = err_flag; on = err_nblk;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode_exact = 1'b0;
      out_ready = 1'b0; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || sum !== 33'h0 || err_flag !== 1'b0 ||
          err_nblk !== 3'd0 || err_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got ov=%b sum=%h ef=%b nb=%0d cnt=%0d, want 0 0 0 0 0",
                  out_valid, sum, err_flag, err_nblk, err_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      cnt_m = 0;
   endtask

   task automatic test_directed();
      logic [31:0] va [6] = '{32'h12345678, 32'h12345678, 32'h000000FF, 32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] vb [6] = '{32'h11111111, 32'h11111111, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
      logic        vm [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [32:0] vs [6] = '{33'h023456789, 33'h023456789, 33'h000000000, 33'h000000100, 33'h0FFFFFF00, 33'h100000000};
      int          vn [6] = '{0, 0, 1, 1, 6, 6};
      int          vl [6] = '{2, 2, 2, 3, 2, 8};
      logic [32:0] s; logic f; logic [2:0] n; int lat;
      for (int i = 0; i < 6; i++) begin
         run_txn(va[i], vb[i], vm[i], 1'b0, s, f, n, lat);
         cnt_m = cnt_next(cnt_m, vn[i], 1'b0);
         n_cmp++;
         if (s !== vs[i] || f !== (vn[i] != 0) || n !== 3'(vn[i])) begin
            n_bad++;
            $display("FAIL directed_%0d result: got sum=%h ef=%b nb=%0d, want sum=%h ef=%b nb=%0d",
                     i, s, f, n, vs[i], vn[i] != 0, vn[i]);
         end
         n_cmp++;
         if (lat != vl[i]) begin
            n_bad++;
            $display("FAIL directed_%0d latency: got %0d, want %0d", i, lat, vl[i]);
         end
         n_cmp++;
         if (err_cnt !== 4'(cnt_m)) begin
            n_bad++;
            $display("FAIL directed_%0d err_cnt: got %0d, want %0d", i, err_cnt, cnt_m);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] ra, rb; logic rm;
      logic [32:0] s, es; logic f; logic [2:0] n; int lat, en, el;
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         // Half the operands are biased toward long propagate chains.
         if (i % 2 == 0) rb = $urandom;
         else            rb = ~ra ^ ($urandom & $urandom & $urandom);
         rm = $urandom_range(0, 1);
         ref_model(ra, rb, rm, es, en, el);
         run_txn(ra, rb, rm, 1'b0, s, f, n, lat);
         cnt_m = cnt_next(cnt_m, en, 1'b0);
         n_cmp++;
         if (s !== es || f !== (en != 0) || n !== 3'(en) || lat != el) begin
            n_bad++;
            $display("FAIL random_%0d a=%h b=%h m=%b: got sum=%h ef=%b nb=%0d lat=%0d, want sum=%h ef=%b nb=%0d lat=%0d",
                     i, ra, rb, rm, s, f, n, lat, es, en != 0, en, el);
         end
         n_cmp++;
         if (err_cnt !== 4'(cnt_m) || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL random_%0d state: got cnt=%0d in_ready=%b, want cnt=%0d in_ready=1",
                     i, err_cnt, in_ready, cnt_m);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      a = 32'h000000FF; b = 32'h00000001; mode_exact = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      cnt_m = cnt_next(cnt_m, 1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         a = 32'h000000FF; b = 32'h00000001; mode_exact = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 33'h0 ||
             err_flag !== 1'b1 || err_nblk !== 3'd1) begin
            n_bad++;
            $display("FAIL backpressure_hold_%0d: got ov=%b ir=%b sum=%h ef=%b nb=%0d, want 1 0 0 1 1",
                     c, out_valid, in_ready, sum, err_flag, err_nblk);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || err_cnt !== 4'(cnt_m)) begin
         n_bad++;
         $display("FAIL backpressure_release: got ir=%b ov=%b cnt=%0d, want 1 0 %0d",
                  in_ready, out_valid, err_cnt, cnt_m);
      end
   endtask

   task automatic test_reset_mid_corr();
      logic [32:0] s; logic f; logic [2:0] n; int lat;
      a = 32'hFFFFFFFF; b = 32'h00000001; mode_exact = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || sum !== 33'h0 || err_flag !== 1'b0 ||
          err_nblk !== 3'd0 || err_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL reset_mid_corr: got ov=%b sum=%h ef=%b nb=%0d cnt=%0d, want 0 0 0 0 0",
                  out_valid, sum, err_flag, err_nblk, err_cnt);
      end
      cnt_m = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_mid_corr_ready: got %b, want 1", in_ready);
      end
      run_txn(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, s, f, n, lat);
      cnt_m = cnt_next(cnt_m, 6, 1'b0);
      n_cmp++;
      if (s !== 33'h100000000 || n !== 3'd6 || lat != 8 || err_cnt !== 4'(cnt_m)) begin
         n_bad++;
         $display("FAIL after_reset_txn: got sum=%h nb=%0d lat=%0d cnt=%0d, want 100000000 6 8 %0d",
                  s, n, lat, err_cnt, cnt_m);
      end
   endtask

   task automatic test_saturation();
      logic [32:0] s; logic f; logic [2:0] n; int lat;
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      cnt_m = 0;
      n_cmp++;
      if (err_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL idle_clear: got %0d, want 0", err_cnt);
      end
      for (int i = 0; i < 17; i++) begin
         run_txn(32'h000000FF, 32'h00000001, 1'b0, 1'b0, s, f, n, lat);
         cnt_m = cnt_next(cnt_m, 1, 1'b0);
      end
      n_cmp++;
      if (err_cnt !== 4'd15 || cnt_m != 15) begin
         n_bad++;
         $display("FAIL saturate: got %0d, want 15", err_cnt);
      end
      run_txn(32'h000000FF, 32'h00000001, 1'b0, 1'b1, s, f, n, lat);
      cnt_m = cnt_next(cnt_m, 1, 1'b1);
      n_cmp++;
      if (err_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL clear_over_incr: got %0d, want 0", err_cnt);
      end
      run_txn(32'h000000FF, 32'h00000001, 1'b1, 1'b0, s, f, n, lat);
      cnt_m = cnt_next(cnt_m, 1, 1'b0);
      n_cmp++;
      if (err_cnt !== 4'(cnt_m) || s !== 33'h000000100 || lat != 3) begin
         n_bad++;
         $display("FAIL post_clear_txn: got cnt=%0d sum=%h lat=%0d, want %0d 000000100 3",
                  err_cnt, s, lat, cnt_m);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_mid_corr();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aca_csu_vl_ctrl.md
Name: aca_csu_vl_ctrl

Overview:
- Variable-latency controller around the 32-bit ACA-CSU approximate adder datapath.
- Each accepted operand pair is added speculatively, using the ACA-CSU carry rule with the carry-select control tied low.
- Blocks whose speculated carry-in is wrong are detected.
- In exact mode, the controller then corrects one wrong block per cycle, re-adding it with its true carry-in, which is the carry-select control=1 path.
- It also reports per-transaction error data and a saturating error counter, for accuracy/energy characterisation benches.

Parameters:
- WIDTH, 32, operand width; must be a multiple of BLK.
- BLK, 4, carry-lookahead block width; NBLK = WIDTH/BLK blocks.
- CNT_W, 16, width of the saturating error-transaction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller idle, can accept.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode_exact  in  1  sampled with the operands: 1 = correct to exact sum, 0 = return speculative sum.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  result; MSB is carry-out.
- err_flag  out  1  speculative result had at least one wrong block carry.
- err_nblk  out  clog2(NBLK)  number of blocks with a wrong speculated carry-in (popcount of the mask).
- err_cnt  out  CNT_W  count of transactions with err_flag=1, saturating.
- cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Block signals: p=a^b, g=a&b; block k covers bits [BLK*k+BLK-1 : BLK*k].
  - G_k is the group generate with cin=0.
  - BP_k is the AND of p over block k.
- Speculative carry into block k:
  - Block 0: 0.
  - Block 1: G_0.
  - Block k≥2: BP_{k-1} ? g[BLK*(k-1)-1] : G_{k-1}.
  - Carry-out (sum[WIDTH]) is the carry out of block NBLK-1 computed with its speculative cin.
- Exact carries: c_0=0; c_k = G_{k-1} | BP_{k-1}&c_{k-1}.
- Error mask: bit k (1..NBLK-1) = speculative cin_k != exact c_k.
- States: IDLE, SPEC, CORR, DONE. in_ready = (state==IDLE).
- IDLE:
  - On in_valid&in_ready, register a, b and mode_exact; go to SPEC.
- SPEC (one cycle):
  - Register the speculative sum and the error mask.
  - Set err_flag = |mask and err_nblk = popcount(mask).
  - If mask==0 or mode_exact==0, go to DONE. Otherwise go to CORR.
- CORR:
  - Each cycle, take the lowest set mask bit k.
  - Recompute sum bits of block k with cin = exact c_k. If k==NBLK-1, also recompute sum[WIDTH].
  - Clear bit k.
  - When the cleared mask is zero, go to DONE.
- DONE:
  - out_valid=1; sum, err_flag and err_nblk are held stable.
  - On out_valid&out_ready, go to IDLE.
- Latency, counted as clock edges from the accept edge to out_valid high:
  - Approximate mode, or no error: 2.
  - Exact mode with errors: 2 + err_nblk.
- There is no pipelining: one transaction in flight at a time.
- err_cnt:
  - Increments on the SPEC→next edge when mask≠0, in both modes.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment.
- Inputs are ignored outside IDLE. out_ready is ignored outside DONE.
- Reset (asynchronous, any state):
  - state=IDLE.
  - out_valid=0, sum=0, err_flag=0, err_nblk=0, err_cnt=0, mask=0.
  - in_ready=1 while rst_n is high after reset.
  - Any in-flight transaction is dropped.

Test Plan:
- a=0x12345678, b=0x11111111, mode_exact=0 and =1 -> sum=0x023456789, err_flag=0, err_nblk=0, latency 2 edges in both modes, err_cnt unchanged.
- a=0x000000FF, b=0x00000001, mode_exact=0 -> sum=0x000000000, err_flag=1, err_nblk=1, latency 2, err_cnt+1. Same operands with mode_exact=1 -> sum=0x000000100, latency 3.
- a=0xFFFFFFFF, b=0x00000001:
  - mode_exact=0 -> sum=0x0FFFFFF00, err_nblk=6 (mask bits k=2..7), latency 2.
  - mode_exact=1 -> sum=0x100000000, latency 8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, err_flag and err_nblk stay stable; in_ready=0; a new in_valid is ignored. Release -> IDLE next cycle.
- Assert rst_n=0 mid-CORR in the all-ones case -> all outputs are at reset values immediately; the next transaction behaves normally.
- CNT_W=4: 17 erroneous transactions -> err_cnt saturates at 15. Assert cnt_clr on the same cycle as an increment -> err_cnt=0.
